// File: rtl/apb_wrr_access_arb.sv
// rtl/apb_wrr_access_arb.sv - weighted round-robin grant sequencer for APB access channels
//
// Ports:
//   clk     rising-edge clock
//   rstn    asynchronous active-low reset
//   req     per-channel pending-transfer flags
//   weight  per-channel extra-grant budget, field i = weight[i*WW +: WW]
//   done    one-cycle pulse: current APB transfer finished
//   en      one-hot, one-cycle grant pulse
//   cur     index of the most recently granted channel
//   busy    high while a grant is issued or its transfer is outstanding
module apb_wrr_access_arb #(
    parameter int NCH = 2,
    parameter int WW  = 2,
    parameter int IW  = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*WW-1:0] weight,
    input  logic              done,
    output logic [NCH-1:0]    en,
    output logic [IW-1:0]     cur,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [IW-1:0] cur_d;
    logic [WW-1:0] cnt;
    logic [WW-1:0] cnt_d;

    logic          rr_found;
    logic [IW-1:0] rr_pick;
    int            rr_dist;
    int            rr_best;
    logic          req_cur;
    logic [WW-1:0] weight_cur;

    // Round-robin search: distance 0 is cur+1, distance NCH-1 is cur itself,
    // so the lowest-distance requester is the next one after cur with wrap.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = cur;
        rr_best  = NCH;
        rr_dist  = 0;
        for (int i = 0; i < NCH; i++) begin
            rr_dist = (i + NCH - 1 - int'(cur)) % NCH;
            if (req[i] && (rr_dist < rr_best)) begin
                rr_best  = rr_dist;
                rr_pick  = IW'(i);
                rr_found = 1'b1;
            end
        end
    end

    // Request flag and weight of the current channel, read live so that a
    // weight change only matters at the moment a selection is made.
    always_comb begin
        req_cur    = 1'b0;
        weight_cur = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cur == IW'(i)) begin
                req_cur    = req[i];
                weight_cur = weight[i*WW +: WW];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cur   <= IW'(NCH - 1);
            cnt   <= '0;
        end else begin
            state <= state_d;
            cur   <= cur_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cur_d   = cur;
        cnt_d   = cnt;
        en      = '0;
        busy    = 1'b0;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    cur_d   = rr_pick;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                busy = 1'b1;
                for (int i = 0; i < NCH; i++) begin
                    en[i] = (cur == IW'(i));
                end
                state_d = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (done) begin
                    // cnt stops at weight_cur, so it can never wrap.
                    if (req_cur && (cnt < weight_cur)) begin
                        cnt_d   = cnt + WW'(1);
                        state_d = GRANT;
                    end else if (rr_found) begin
                        cur_d   = rr_pick;
                        cnt_d   = '0;
                        state_d = GRANT;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_wrr_access_arb.sv
// tb/tb_apb_wrr_access_arb.sv - randomized self-checking bench for apb_wrr_access_arb
module tb_apb_wrr_access_arb;

    localparam int NCH = 3;
    localparam int WW  = 2;
    localparam int IW  = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NCH-1:0]    req;
    logic [NCH*WW-1:0] weight;
    logic              done;
    logic [NCH-1:0]    en;
    logic [IW-1:0]     cur;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: transaction-level view of the arbiter.
    bit m_busy;
    bit m_pulse;
    int m_cur;
    int m_used;
    int cd;
    int glog[$];

    always #5 clk = ~clk;

    apb_wrr_access_arb #(.NCH(NCH), .WW(WW), .IW(IW)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .req    (req),
        .weight (weight),
        .done   (done),
        .en     (en),
        .cur    (cur),
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int wf(input logic [NCH*WW-1:0] w, input int c);
        return int'((w >> (c * WW)) & 6'd3);
    endfunction

    function automatic bit has_req(input logic [NCH-1:0] r, input int c);
        return ((r >> c) & 3'd1) != 3'd0;
    endfunction

    function automatic int rr_next(input logic [NCH-1:0] r, input int from);
        for (int k = 1; k <= NCH; k++) begin
            if (has_req(r, (from + k) % NCH)) return (from + k) % NCH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_pulse = 1'b0;
        m_cur   = NCH - 1;
        m_used  = 0;
        cd      = 0;
    endtask

    // Predict the effect of the coming rising edge from the current inputs.
    task automatic model_step();
        int c;
        if (!rstn) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            c = rr_next(req, m_cur);
            if (c >= 0) begin
                m_cur   = c;
                m_used  = 0;
                m_busy  = 1'b1;
                m_pulse = 1'b1;
            end
        end else if (m_pulse) begin
            m_pulse = 1'b0;
        end else if (done) begin
            if (has_req(req, m_cur) && (m_used < wf(weight, m_cur))) begin
                m_used++;
                m_pulse = 1'b1;
            end else begin
                c = rr_next(req, m_cur);
                m_used = 0;
                if (c >= 0) begin
                    m_cur   = c;
                    m_pulse = 1'b1;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model, check at the next falling edge.
    task automatic step(input logic [NCH-1:0] r, input logic [NCH*WW-1:0] w, input bit spur);
        logic [NCH-1:0] exp_en;
        req    = r;
        weight = w;
        if (m_pulse) cd = 3;
        else if (cd > 0) cd--;
        if (cd == 1) done = 1'b1;
        else if (!m_busy || m_pulse) done = spur;
        else done = 1'b0;
        model_step();
        @(negedge clk);
        exp_en = m_pulse ? NCH'(1 << m_cur) : '0;
        check("en", en, exp_en);
        check("busy", busy, m_busy);
        check("cur", cur, m_cur);
        if (en == 3'b001) glog.push_back(0);
        else if (en == 3'b010) glog.push_back(1);
        else if (en == 3'b100) glog.push_back(2);
        else if (en != 3'b000) glog.push_back(9);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_async_en", en, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_cur", cur, NCH - 1);
        model_reset();
        done = 1'b0;
        @(negedge clk);
        check("rst_hold_en", en, 0);
        check("rst_hold_cur", cur, NCH - 1);
        rstn = 1'b1;
    endtask

    int exp029[8] = '{0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        int lim;
        bit saw_idle;
        logic [NCH-1:0]    r;
        logic [NCH*WW-1:0] w;

        rstn   = 1'b0;
        req    = '0;
        weight = '0;
        done   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_en", en, 0);
        check("reset_busy", busy, 0);
        check("reset_cur", cur, 2);
        rstn = 1'b1;
        repeat (4) step(3'b000, '0, 1'b0);

        // Equal weights, all requesting.
        glog.delete();
        lim = 0;
        while (glog.size() < 6 && lim < 60) begin
            step(3'b111, '0, 1'b0);
            lim++;
        end
        check("rr_count", glog.size(), 6);
        for (int i = 0; i < 6; i++)
            check("rr_order", (i < glog.size()) ? glog[i] : -1, i % 3);

        // Weighted: ch0 weight 2, ch1 weight 0.
        glog.delete();
        lim = 0;
        while (glog.size() < 8 && lim < 80) begin
            step(3'b011, 6'b000010, 1'b0);
            lim++;
        end
        check("wrr_count", glog.size(), 8);
        for (int i = 0; i < 8; i++)
            check("wrr_order", (i < glog.size()) ? glog[i] : -1, exp029[i]);

        // Lone requester keeps the bus.
        glog.delete();
        lim = 0;
        saw_idle = 1'b0;
        while (glog.size() < 6 && lim < 60) begin
            step(3'b100, '0, 1'b0);
            if (!busy) saw_idle = 1'b1;
            lim++;
        end
        check("solo_count", glog.size(), 6);
        for (int i = 0; i < 6; i++)
            check("solo_chan", (i < glog.size()) ? glog[i] : -1, 2);
        check("solo_never_idle", saw_idle, 0);

        // Drain to idle, then spurious done in IDLE and GRANT, req dropped in WAIT.
        lim = 0;
        while (m_busy && lim < 20) begin
            step(3'b000, '0, 1'b0);
            lim++;
        end
        check("drain_idle", busy, 0);
        repeat (3) step(3'b000, '0, 1'b1);
        glog.delete();
        step(3'b001, '0, 1'b1);
        step(3'b000, '0, 1'b1);
        repeat (4) step(3'b000, '0, 1'b0);
        check("drop_grants", glog.size(), 1);
        check("drop_idle", busy, 0);

        // Reset while waiting on channel 1.
        step(3'b010, '0, 1'b0);
        step(3'b010, '0, 1'b0);
        check("wait_cur", cur, 1);
        check("wait_busy", busy, 1);
        do_reset();
        step(3'b111, '0, 1'b0);
        check("post_rst_en", en, 3'b001);

        // Randomized traffic with occasional resets.
        r = 3'b111;
        w = '0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) r = 3'($urandom);
            if ($urandom_range(0, 7) == 0) w = 6'($urandom);
            step(r, w, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_wrr_access_arb.md
APB_WRR_ACCESS_ARB -- requirements
Module: apb_wrr_access_arb

Interface
REQ-001 Parameter NCH, default 2, number of request channels; legal range 2..8.
REQ-002 Parameter WW, default 2, width of each per-channel weight field.
REQ-003 Parameter IW, default 1, channel-index width; SHALL equal max(1, ceil(log2(NCH))).
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NCH  per-channel access available; bit i = channel i has a transfer pending.
REQ-007 weight  input  NCH*WW  field i = bits [i*WW +: WW]; channel i may take weight[i]+1 consecutive grants while others wait.
REQ-008 done  input  1  single-cycle pulse: the APB transfer in progress has completed.
REQ-009 en  output  NCH  one-hot, one-cycle grant pulse to the selected channel.
REQ-010 cur  output  IW  index of the most recently granted channel.
REQ-011 busy  output  1  high while in GRANT or WAIT.

Function
REQ-012 The FSM SHALL have three states: IDLE, GRANT and WAIT.
REQ-013 IDLE: if any req bit is high, the block SHALL select a channel by round-robin (REQ-016), load cur, clear cnt and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-014 GRANT: en[cur] SHALL be 1 for exactly this cycle, all other en bits 0; next state WAIT unconditionally.
REQ-015 WAIT: the block SHALL hold until done=1; on done, if any req bit is high it SHALL select per REQ-016/017 and go to GRANT, else go to IDLE.
REQ-016 Round-robin search SHALL start at cur+1 (mod NCH), wrap around, and pick the first channel with req=1; it may return cur itself when cur is the only requester.
REQ-017 On done in WAIT, if req[cur]=1 and cnt < weight[cur], the block SHALL re-grant cur and increment cnt; otherwise it SHALL use REQ-016 and clear cnt to 0.
REQ-018 cnt SHALL be WW bits wide and SHALL never wrap, because the compare in REQ-017 stops it at weight[cur].
REQ-019 When only one channel requests, it SHALL be granted on every turn regardless of weight; cnt SHALL clear to 0 on every re-grant that comes through REQ-016.
REQ-020 Latency: req sampled in IDLE at cycle t -> en pulse at t+1; done at cycle t -> next en at t+1.
REQ-021 done outside WAIT SHALL be ignored.
REQ-022 A req drop during WAIT SHALL NOT abort the transfer; req is evaluated only at selection time.
REQ-023 weight SHALL be sampled only at selection time; changes mid-burst take effect at the next selection.
REQ-024 en SHALL be zero in IDLE and WAIT, and SHALL never have more than one bit set.

Reset
REQ-025 On rstn low, the block SHALL asynchronously force state=IDLE, en=0, busy=0, cnt=0 and cur=NCH-1, so channel 0 has first priority after reset.
REQ-026 A reset during GRANT or WAIT SHALL drop the transfer in progress with no further en pulse; the first grant after reset SHALL follow REQ-025.

Verification (NCH=3, WW=2; done pulsed 2 cycles after each en)
REQ-027 Reset with req=000 -> en=000, busy=0, cur=2, holds in IDLE.
REQ-028 req=111, all weights 0 -> grant order 0,1,2,0,1,2; en pulse exactly one cycle after each done.
REQ-029 req=011, weight[0]=2, weight[1]=0 -> grant order 0,0,0,1,0,0,0,1.
REQ-030 req=100 only, weight[2]=0 -> ch2 granted on every turn, busy continuously 1, never returns to IDLE.
REQ-031 done pulsed in IDLE and in GRANT -> no state change; req dropped to 000 in WAIT -> done returns the FSM to IDLE with no en.
REQ-032 rstn asserted in WAIT with cur=1 -> en=000, IDLE, cur=2; then req=111 -> first en=001.
